// File: rtl/carp_dbg_pkg.sv
// Shared types and default widths for the CARP/EEL data-memory dump engine.
package carp_dbg_pkg;

    localparam int unsigned DEF_ADDR_W = 14;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } dump_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } dump_word_t;

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry FIFO holding {addr, data} words between the memory read and the stream port.
module dump_fifo2
    import carp_dbg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  dump_word_t push_data,
    input  logic       pop,
    output dump_word_t pop_data,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    dump_word_t mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;

endmodule

// File: rtl/dmem_dump_engine.sv
// Dumps a window of DATA_MEMORY words as {addr, data} over valid/ready while holding the core.
module dmem_dump_engine
    import carp_dbg_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              core_hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   issued_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_addr_q;
    logic [ADDR_W:0]   clamped_count;
    logic              pop;
    logic              credit_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    dump_word_t        fifo_in;
    dump_word_t        fifo_head;

    assign clamped_count = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
    assign pop           = out_valid && out_ready;
    // Reserve a slot for every read whose data has not yet landed in the FIFO.
    assign credit_ok     = ({1'b0, fifo_count} + {2'b0, inflight_q} + 3'd1)
                           <= (3'(FIFO_DEPTH) + {2'b0, pop});
    assign mem_addr      = base_q + issued_q[ADDR_W-1:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (clamped_count == '0) ? FIN : RUN;
            RUN:     if (issued_q == count_q) state_d = DRAIN;
            DRAIN:   if (!inflight_q && (fifo_empty || (fifo_count == 2'd1 && pop))) begin
                         state_d = FIN;
                     end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        core_hold = busy;
        done      = (state_q == FIN);
        mem_rd_en = (state_q == RUN) && (issued_q < count_q) && credit_ok;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            base_q          <= '0;
            count_q         <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                base_q   <= base_addr;
                count_q  <= clamped_count;
                issued_q <= '0;
            end else if (mem_rd_en) begin
                issued_q <= issued_q + 1'b1;
            end
            inflight_q <= mem_rd_en;
            if (mem_rd_en) begin
                inflight_addr_q <= mem_addr;
            end
        end
    end

    assign fifo_in = '{addr: inflight_addr_q, data: mem_rdata};

    dump_fifo2 u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (inflight_q),
        .push_data (fifo_in),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_addr  = out_valid ? fifo_head.addr : '0;
    assign out_data  = out_valid ? fifo_head.data : '0;

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RST)
        !(fifo_full && inflight_q && !pop));

endmodule

// File: tb/tb_dmem_dump_engine.sv
// Scoreboard bench for dmem_dump_engine: expected words queued at start, popped by a monitor.
module tb_dmem_dump_engine;

    localparam int AW = 14;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          busy, done, core_hold, mem_rd_en, out_valid;
    logic [AW-1:0] mem_addr, out_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            hs_count = 0;
    int            last_hs_cyc = 0;
    int            tb_out = 0;
    bit            bp_mode = 1'b0;
    int            bp_ph = 0;
    logic          mon_pop;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    dmem_dump_engine dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .core_hold  (core_hold),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data)
    );

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return 32'hA000_0000 | {18'b0, a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    // Memory model: one-cycle read latency.
    always @(posedge CLK) mem_rdata <= mem_rd_en ? memval(mem_addr) : '0;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (bp_mode) begin
                out_ready = (bp_ph == 0) || (bp_ph == 3);
                bp_ph = (bp_ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            prev_stall = 1'b0;
            tb_out = 0;
        end else begin
            mon_pop = out_valid && out_ready;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_addr", out_addr, prev_addr);
                check("stall_data", out_data, prev_data);
            end
            if (mem_rd_en) check("fifo_credit", (tb_out + 1 - int'(mon_pop)) <= 2, 1);
            if (mon_pop) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_word: got addr %0h data %0h expected none",
                             out_addr, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_addr", out_addr, mon_e.a);
                    check("word_data", out_data, mon_e.d);
                end
                hs_count++;
                last_hs_cyc = cyc;
            end
            tb_out = tb_out + int'(mem_rd_en) - int'(mon_pop);
            prev_stall = out_valid && !out_ready;
            prev_addr = out_addr;
            prev_data = out_data;
        end
    end

    task automatic push_exp(input logic [AW-1:0] b, input logic [AW:0] c);
        int n;
        exp_t t;
        n = (c > 15'h4000) ? 'h4000 : int'(c);
        for (int i = 0; i < n; i++) begin
            t.a = b + i[AW-1:0];
            t.d = memval(t.a);
            exp_q.push_back(t);
        end
    endtask

    task automatic start_dump(input logic [AW-1:0] b, input logic [AW:0] c);
        push_exp(b, c);
        @(posedge CLK);
        #1;
        start = 1'b1;
        base_addr = b;
        word_count = c;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int done_cyc);
        int k;
        k = 0;
        done_cyc = -1;
        while (k < budget) begin
            @(negedge CLK);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            k++;
        end
        check({name, "_done_seen"}, done_cyc >= 0, 1);
    endtask

    initial begin
        int dc;
        int k0;
        int hs0;

        #12;
        check("reset_outputs", {busy, done, core_hold, mem_rd_en, mem_addr, out_valid,
                                out_addr, out_data}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // Basic full-throughput dump
        start_dump(14'h0000, 15'd4);
        k0 = cyc;
        @(negedge CLK);
        check("basic_c1", {busy, core_hold, mem_rd_en, out_valid}, 4'b1110);
        @(negedge CLK);
        check("basic_c2", {busy, core_hold, mem_rd_en, out_valid}, 4'b1110);
        @(negedge CLK);
        check("basic_first_valid", {out_valid, out_addr}, {1'b1, 14'h0000});
        wait_done("basic", 40, dc);
        check("basic_done_cycle", dc - k0, 6);
        check("basic_done_after_hs", dc - last_hs_cyc, 1);
        check("basic_fin_flags", {busy, core_hold, done}, 3'b111);
        check("basic_all_words", exp_q.size(), 0);
        @(negedge CLK);
        check("basic_idle_flags", {busy, core_hold, done}, 3'b000);

        // Backpressure
        bp_ph = 0;
        bp_mode = 1'b1;
        start_dump(14'h0040, 15'd8);
        wait_done("bp", 200, dc);
        check("bp_done_after_hs", dc - last_hs_cyc, 1);
        check("bp_all_words", exp_q.size(), 0);
        bp_mode = 1'b0;

        // Address wrap
        start_dump(14'h3FFE, 15'd4);
        wait_done("wrap", 40, dc);
        check("wrap_all_words", exp_q.size(), 0);

        // Zero count
        start_dump(14'h0123, 15'd0);
        @(negedge CLK);
        check("zero_fin", {busy, done, core_hold, mem_rd_en, out_valid}, 5'b11100);
        @(negedge CLK);
        check("zero_idle", {busy, done, core_hold, mem_rd_en, out_valid}, 5'b00000);

        // Start while busy ignored; start after done accepted
        start_dump(14'h0000, 15'd6);
        @(posedge CLK);
        #1;
        start = 1'b1;
        base_addr = 14'h0100;
        word_count = 15'd6;
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done("ign", 40, dc);
        check("ign_all_words", exp_q.size(), 0);
        start = 1'b1;
        base_addr = 14'h0200;
        word_count = 15'd3;
        @(posedge CLK);
        #1;
        base_addr = 14'h0100;
        word_count = 15'd2;
        push_exp(14'h0100, 15'd2);
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done("after_done", 40, dc);
        check("after_done_words", exp_q.size(), 0);

        // Async reset mid-dump
        start_dump(14'h0000, 15'd8);
        hs0 = hs_count;
        for (int k = 0; k < 30 && hs_count < hs0 + 3; k++) @(negedge CLK);
        check("rst_three_words", hs_count >= hs0 + 3, 1);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("rst_async_outputs", {busy, done, core_hold, mem_rd_en, mem_addr, out_valid,
                                    out_addr, out_data}, 0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("rst_quiet", {done, busy, out_valid, mem_rd_en}, 4'b0000);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        start_dump(14'h2000, 15'd3);
        wait_done("post_rst", 40, dc);
        check("post_rst_words", exp_q.size(), 0);

        // Oversized count clamps to the full address space
        start_dump(14'h0005, 15'h7FFF);
        wait_done("clamp", 16384 + 60, dc);
        check("clamp_all_words", exp_q.size(), 0);
        @(negedge CLK);
        check("clamp_no_extra", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
